// File: rtl/sprite_blitter.sv
// ---------------------------------------------------------------------------
// sprite_blitter
//   Copies a spr_w x spr_h sprite from a sync-read sprite RAM into a
//   sync-write FB_WIDTH x FB_HEIGHT frame RAM at (dst_x,dst_y), one pixel per
//   clock in raster order. Pixels falling off the right/bottom edge are read
//   but not written.
//
//   Optional feature macro: BLIT_COLORKEY_EN
//     defined   -> pixels whose src_data == KEY_COLOR are not written
//     undefined -> every unclipped pixel is written
//
// Ports
//   Clk, Reset_n        clock, asynchronous active-low reset
//   start               launch (sampled only while idle)
//   src_base            sprite RAM address of pixel (0,0)
//   spr_w, spr_h        sprite size
//   dst_x, dst_y        frame position of pixel (0,0)
//   busy, done          status / one-cycle completion pulse
//   src_read_addr       sprite RAM read address
//   src_data            sprite RAM read data (1-cycle latency)
//   dst_write_addr      frame RAM write address
//   dst_data, dst_we    frame RAM write data / strobe
// ---------------------------------------------------------------------------
module sprite_blitter #(
    parameter int                DATA_W    = 8,
    parameter int                SRC_AW    = 13,
    parameter int                DST_AW    = 19,
    parameter int                DIM_W     = 9,
    parameter int                FB_WIDTH  = 320,
    parameter int                FB_HEIGHT = 240,
    parameter logic [DATA_W-1:0] KEY_COLOR = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [DIM_W-1:0]  spr_w,
    input  logic [DIM_W-1:0]  spr_h,
    input  logic [DIM_W-1:0]  dst_x,
    input  logic [DIM_W-1:0]  dst_y,
    output logic              busy,
    output logic              done,
    output logic [SRC_AW-1:0] src_read_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic [DST_AW-1:0] dst_write_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_we
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [DIM_W:0]    FBW_C = (DIM_W+1)'(FB_WIDTH);
    localparam logic [DIM_W:0]    FBH_C = (DIM_W+1)'(FB_HEIGHT);
    localparam logic [DST_AW-1:0] FBW_A = DST_AW'(FB_WIDTH);

    state_t            state, state_n;
    logic [DIM_W-1:0]  w_q, h_q, x_q;     // latched geometry
    logic [DIM_W-1:0]  col, row;          // pixel currently on src_read_addr
    logic [DIM_W:0]    px, py;            // frame coords, one extra bit so no wrap
    logic [DST_AW-1:0] row_base;          // frame address of (dst_x, dst_y+row)
    logic [DST_AW-1:0] pix_addr;          // frame address of current pixel
    logic [DST_AW-1:0] start_base;
    logic              s1_vld, s1_we;     // stage 1: tag for the outstanding read
    logic [DST_AW-1:0] s1_addr;
    logic              drain_cnt;
    logic              col_end, last, zero_size, key_drop;

    // Constant multiply only at launch; the pixel path is purely incremental.
    assign start_base = DST_AW'(dst_y) * FBW_A + DST_AW'(dst_x);
    assign zero_size  = (spr_w == '0) || (spr_h == '0);
    assign col_end    = (col == w_q - 1'b1);
    assign last       = col_end && (row == h_q - 1'b1);
    assign busy       = (state != IDLE);

`ifdef BLIT_COLORKEY_EN
    assign key_drop = (src_data == KEY_COLOR);
`else
    // Comparator gated off: every unclipped pixel is written.
    assign key_drop = (src_data == KEY_COLOR) & 1'b0;
`endif

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // FSM next state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = zero_size ? DRAIN : READ;
            READ:    if (last) state_n = DRAIN;
            DRAIN:   if (drain_cnt) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address generation: counters advance once per issued read.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            w_q <= '0; h_q <= '0; x_q <= '0;
            col <= '0; row <= '0; px <= '0; py <= '0;
            row_base <= '0; pix_addr <= '0; src_read_addr <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    w_q <= spr_w; h_q <= spr_h; x_q <= dst_x;
                    col <= '0; row <= '0;
                    px <= {1'b0, dst_x}; py <= {1'b0, dst_y};
                    row_base <= start_base; pix_addr <= start_base;
                    src_read_addr <= src_base;
                end
                READ: if (!last) begin
                    src_read_addr <= src_read_addr + 1'b1;
                    if (col_end) begin
                        col      <= '0;
                        row      <= row + 1'b1;
                        px       <= {1'b0, x_q};
                        py       <= py + 1'b1;
                        row_base <= row_base + FBW_A;
                        pix_addr <= row_base + FBW_A;
                    end else begin
                        col      <= col + 1'b1;
                        px       <= px + 1'b1;
                        pix_addr <= pix_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Two-stage write pipeline plus drain/done.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_vld <= 1'b0; s1_we <= 1'b0; s1_addr <= '0;
            dst_we <= 1'b0; dst_write_addr <= '0; dst_data <= '0;
            drain_cnt <= 1'b0; done <= 1'b0;
        end else begin
            s1_vld  <= (state == READ);
            s1_we   <= (state == READ) && (px < FBW_C) && (py < FBH_C);
            s1_addr <= pix_addr;
            dst_we  <= s1_vld && s1_we && !key_drop;
            if (s1_vld) begin
                dst_write_addr <= s1_addr;
                dst_data       <= src_data;
            end
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            done      <= (state == DRAIN) && drain_cnt;
        end
    end

endmodule
